input_buffer: RTL and testbench

Receives 16-bit command words from the MCU over an asynchronous four-phase `mcu_rts`/`cts` handshake. Captured words are buffered in a small FIFO and presented to FPGA-side logic with a valid/ready interface. This block is the MCU-to-FPGA counterpart of the FPGA-to-MCU output path. Both directions share the same 16-bit word format and the same pin-level rts/cts semantics.

---
 rtl/input_buffer_pkg.sv | 13 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/input_buffer.sv | 104 ++++++++++
 tb/tb_input_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_buffer_pkg.sv
// Shared definitions for the MCU-to-FPGA input path.
// MCU_WORD_WIDTH is the one definition of the MCU word, common to both directions.
package input_buffer_pkg;

    localparam int MCU_WORD_WIDTH     = 16;
    localparam int FIFO_DEPTH_DEFAULT = 8;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Writes while full and reads while empty are ignored.
module sync_fifo
    import input_buffer_pkg::*;
#(
    parameter int WIDTH = MCU_WORD_WIDTH,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign count = count_q;

    // Head word is forced to zero while empty so the output is defined from reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/input_buffer.sv
// MCU-to-FPGA command path: four-phase rts/cts capture into a FIFO,
// presented downstream as a valid/ready stream.
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int WIDTH = MCU_WORD_WIDTH,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           mcu_data,
    input  logic                       mcu_rts,
    output logic                       cts,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_e;

    hs_state_e state;
    hs_state_e state_next;
    logic      rts_meta;
    logic      rts_s;
    logic      cts_q;
    logic      cts_next;
    logic      wr_en;
    logic      fifo_full;
    logic      fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rts_meta <= 1'b0;
            rts_s    <= 1'b0;
        end else begin
            rts_meta <= mcu_rts;
            rts_s    <= rts_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cts_q <= 1'b0;
        end else begin
            state <= state_next;
            cts_q <= cts_next;
        end
    end

    // mcu_data is only sampled on the IDLE->ACK edge, when rts_s guarantees it is stable.
    // Once in ACK the handshake runs to completion regardless of enable or full.
    always_comb begin
        state_next = state;
        cts_next   = cts_q;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (rts_s && enable && !fifo_full) begin
                    state_next = ACK;
                    cts_next   = 1'b1;
                    wr_en      = 1'b1;
                end
            end
            ACK: begin
                if (!rts_s) begin
                    state_next = IDLE;
                    cts_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                cts_next   = 1'b0;
            end
        endcase
    end

    assign cts = cts_q;

    // Downstream handshake: a word transfers on every edge where out_valid && out_ready;
    // out_valid never waits on out_ready, and out_ready while empty is ignored.
    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (mcu_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: MCU-side rts/cts driver, downstream consumer and
// an ordered scoreboard of the words the MCU has handed over.
module tb_input_buffer;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  mcu_data;
  logic          mcu_rts;
  logic          cts;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  logic         cons_en   = 1'b0;
  logic         cons_rand = 1'b0;

  always #5 clk = ~clk;

  input_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mcu_data  (mcu_data),
    .mcu_rts   (mcu_rts),
    .cts       (cts),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  // Consumer: picks out_ready at the falling edge; a word seen valid there with
  // ready high is taken at the following rising edge.
  always @(negedge clk) begin
    if (cons_en) begin
      if (cons_rand) out_ready = 1'($urandom_range(0, 1));
      else           out_ready = ~out_ready;
      if (out_ready && out_valid) rx_q.push_back(out_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cts(input logic val, input int budget, input string name);
    int n = 0;
    while (cts !== val && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (cts !== val) begin
      errors++;
      $display("FAIL %s: cts=%b required %b within %0d cycles", name, cts, val, budget);
    end
  endtask

  task automatic send_word(input logic [W-1:0] d);
    mcu_data = d;
    mcu_rts  = 1'b1;
    wait_cts(1'b1, 60, "send_ack");
    exp_q.push_back(d);
    mcu_rts = 1'b0;
    wait_cts(1'b0, 60, "send_release");
  endtask

  task automatic drain;
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid: out_valid=%b required 1", out_valid);
      end
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL drain_data: out_data=%h required %h", out_data, exp_q[0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d out_valid=%b required 0 0", count, out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; mcu_rts = 1'b0; mcu_data = '0; out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (cts !== 1'b0 || count !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: cts=%b count=%0d valid=%b data=%h required 0 0 0 0000",
               cts, count, out_valid, out_data);
    end
    reset  = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_single_word;
    mcu_data = 16'hA5C3;
    mcu_rts  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (cts !== (i == 3)) begin
        errors++;
        $display("FAIL single_rise edge%0d: cts=%b required %b", i, cts, (i == 3));
      end
    end
    checks++;
    if (out_data !== 16'hA5C3 || out_valid !== 1'b1 || count !== CW'(1)) begin
      errors++;
      $display("FAIL single_capture: data=%h valid=%b count=%0d required a5c3 1 1",
               out_data, out_valid, count);
    end
    exp_q.push_back(16'hA5C3);
    mcu_rts = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (cts !== (i < 3)) begin
        errors++;
        $display("FAIL single_fall edge%0d: cts=%b required %b", i, cts, (i < 3));
      end
    end
    checks++;
    if (count !== CW'(1)) begin
      errors++;
      $display("FAIL single_count_hold: count=%0d required 1", count);
    end
    drain();
  endtask

  task automatic test_full_stall;
    logic saw = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= D; i++) send_word(W'(i));
    checks++;
    if (count !== CW'(D)) begin
      errors++;
      $display("FAIL full_count: count=%0d required %0d", count, D);
    end
    mcu_data = 16'h0009;
    mcu_rts  = 1'b1;
    repeat (25) begin
      tick();
      if (cts) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || count !== CW'(D)) begin
      errors++;
      $display("FAIL full_stall: cts_seen=%b count=%0d required 0 %0d", saw, count, D);
    end
    checks++;
    if (out_data !== 16'h0001) begin
      errors++;
      $display("FAIL full_head: out_data=%h required 0001", out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (count !== CW'(D - 1)) begin
      errors++;
      $display("FAIL full_pop: count=%0d required %0d", count, D - 1);
    end
    wait_cts(1'b1, 10, "full_resume");
    exp_q.push_back(16'h0009);
    checks++;
    if (count !== CW'(exp_q.size())) begin
      errors++;
      $display("FAIL full_refill: count=%0d required %0d", count, exp_q.size());
    end
    mcu_rts = 1'b0;
    wait_cts(1'b0, 10, "full_release");
    drain();
  endtask

  task automatic test_stream(input int n_words, input logic rnd, input string name);
    int cyc = 0;
    exp_q.delete();
    rx_q.delete();
    out_ready = 1'b0;
    cons_rand = rnd;
    cons_en   = 1'b1;
    for (int i = 0; i < n_words; i++) begin
      send_word(rnd ? W'($urandom) : W'(16'h1000 + i));
      if (rnd) repeat ($urandom_range(0, 4)) tick();
    end
    while (rx_q.size() < n_words && cyc < 1000) begin
      tick();
      cyc++;
    end
    cons_en   = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (rx_q.size() != n_words) begin
      errors++;
      $display("FAIL %s_len: received=%0d required %0d", name, rx_q.size(), n_words);
    end
    for (int i = 0; i < n_words && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got=%h required %h", name, i, rx_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    tick();
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: count=%0d valid=%b required 0 0", name, count, out_valid);
    end
  endtask

  task automatic test_enable;
    logic saw = 1'b0;
    enable   = 1'b0;
    mcu_data = 16'h5A5A;
    mcu_rts  = 1'b1;
    repeat (10) begin
      tick();
      if (cts) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL enable_block: cts_seen=%b count=%0d required 0 0", saw, count);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (cts !== 1'b1 || count !== CW'(1)) begin
      errors++;
      $display("FAIL enable_capture: cts=%b count=%0d required 1 1", cts, count);
    end
    exp_q.push_back(16'h5A5A);
    enable  = 1'b0;
    mcu_rts = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (cts !== (i < 3)) begin
        errors++;
        $display("FAIL enable_complete edge%0d: cts=%b required %b", i, cts, (i < 3));
      end
    end
    enable = 1'b1;
    drain();
  endtask

  task automatic test_simultaneous;
    for (int i = 1; i <= 3; i++) send_word(W'(16'h3000 + i));
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL simul_pre: count=%0d required 3", count);
    end
    mcu_data = 16'h3004;
    mcu_rts  = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(16'h3004);
    checks++;
    if (count !== CW'(3) || cts !== 1'b1 || out_data !== exp_q[0]) begin
      errors++;
      $display("FAIL simul_rw: count=%0d cts=%b data=%h required 3 1 %h",
               count, cts, out_data, exp_q[0]);
    end
    mcu_rts = 1'b0;
    wait_cts(1'b0, 10, "simul_release");
    drain();
  endtask

  task automatic test_reset_mid_ack;
    mcu_data = 16'hBEEF;
    mcu_rts  = 1'b1;
    wait_cts(1'b1, 10, "rst_ack");
    checks++;
    if (count !== CW'(1)) begin
      errors++;
      $display("FAIL rst_pre_count: count=%0d required 1", count);
    end
    reset = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if (cts !== 1'b0 || count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ack: cts=%b count=%0d valid=%b required 0 0 0", cts, count, out_valid);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (cts !== (i == 3)) begin
        errors++;
        $display("FAIL rst_recapture edge%0d: cts=%b required %b", i, cts, (i == 3));
      end
    end
    checks++;
    if (count !== CW'(1) || out_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL rst_recapture_data: count=%0d data=%h required 1 beef", count, out_data);
    end
    exp_q.push_back(16'hBEEF);
    mcu_rts = 1'b0;
    wait_cts(1'b0, 10, "rst_release");
    drain();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_stall();
    test_stream(20, 1'b0, "wrap");
    test_enable();
    test_simultaneous();
    test_stream(24, 1'b1, "random");
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
